// File: rtl/timer_arbiter.sv
// Four-requester round-robin arbiter sharing one prescaled tick timer.
// The owner holds the timer for its latched duration; dropping req aborts the run.
module timer_arbiter #(
  parameter int PRESCALE = 100,
  parameter int CNT_W    = 16
) (
  input  logic               i_clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [4*CNT_W-1:0] i_dur,
  output logic [3:0]         gnt,
  output logic [3:0]         done,
  output logic               busy,
  output logic               tick
);

  localparam int PW = $clog2(PRESCALE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       g;
  logic [1:0]       ptr;
  logic [1:0]       sel;
  logic [PW-1:0]    pre;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] durs [4];
  logic [CNT_W-1:0] dur_g;
  logic             wrap;
  logic             found;

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      durs[i] = i_dur[i*CNT_W +: CNT_W];
    end
    dur_g = durs[g];
  end

  assign wrap = (pre == PW'(PRESCALE - 1));

  // Round-robin search starting at ptr; first asserted request wins.
  always_comb begin
    sel   = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!found && req[ptr + 2'(i)]) begin
        sel   = ptr + 2'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (|req) state_nxt = S_LOAD;
      S_LOAD: begin
        if (!req[g])                 state_nxt = S_IDLE;
        else if (dur_g == '0)        state_nxt = S_DONE;
        else                         state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!req[g])                             state_nxt = S_IDLE;
        else if (wrap && cnt == CNT_W'(1))       state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      g     <= '0;
      ptr   <= '0;
      pre   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (|req) g <= sel;
        S_LOAD: begin
          if (req[g]) begin
            cnt <= dur_g;
            pre <= '0;
          end else begin
            ptr <= g + 2'd1;
          end
        end
        S_RUN: begin
          // An abort leaves both counters frozen where they stopped.
          if (req[g]) begin
            if (wrap) begin
              pre <= '0;
              if (cnt != '0) cnt <= cnt - CNT_W'(1);
            end else begin
              pre <= pre + PW'(1);
            end
          end else begin
            ptr <= g + 2'd1;
          end
        end
        S_DONE:  ptr <= g + 2'd1;
        default: ;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign gnt  = busy ? (4'd1 << g) : '0;
  assign done = (state == S_DONE) ? (4'd1 << g) : '0;
  assign tick = (state == S_RUN) && wrap;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter: an elapsed-time model checked every cycle,
// plus hand-computed per-scenario expectations.
module tb_timer_arbiter;

  localparam int P = 4;
  localparam int W = 16;

  logic           i_clk = 1'b0;
  logic           rst   = 1'b1;
  logic [3:0]     req   = '0;
  logic [4*W-1:0] i_dur = '0;
  logic [3:0]     gnt, done;
  logic           busy, tick;

  always #5 i_clk = ~i_clk;

  timer_arbiter #(.PRESCALE(P), .CNT_W(W)) dut (
    .i_clk(i_clk), .rst(rst), .req(req), .i_dur(i_dur),
    .gnt(gnt), .done(done), .busy(busy), .tick(tick)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: an operation is described by its owner, the cycles elapsed since the
  // grant decision (k=1 is the load cycle) and the cycle at which it completes.
  bit         m_act;
  logic [1:0] m_g, m_ptr;
  int         m_k, m_donek;

  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] res;
    bit f;
    res = p;
    f   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!f && r[(p + i) % 4]) begin
        res = 2'((p + i) % 4);
        f   = 1'b1;
      end
    end
    return res;
  endfunction

  always @(posedge i_clk or posedge rst) begin
    if (rst) begin
      m_act <= 1'b0; m_ptr <= '0; m_g <= '0; m_k <= 0; m_donek <= 0;
    end else if (!m_act) begin
      if (req != 0) begin
        m_g <= pick(req, m_ptr); m_act <= 1'b1; m_k <= 1;
      end
    end else if (m_k == 1) begin
      if (!req[m_g]) begin
        m_act <= 1'b0; m_ptr <= m_g + 2'd1;
      end else begin
        m_donek <= 2 + int'(i_dur[m_g*W +: W]) * P; m_k <= 2;
      end
    end else if (m_k == m_donek) begin
      m_act <= 1'b0; m_ptr <= m_g + 2'd1;
    end else if (!req[m_g]) begin
      m_act <= 1'b0; m_ptr <= m_g + 2'd1;
    end else begin
      m_k <= m_k + 1;
    end
  end

  always @(negedge i_clk) begin : cmp
    logic [3:0] eg, ed;
    logic       et;
    eg = m_act ? (4'd1 << m_g) : 4'd0;
    ed = (m_act && m_k >= 2 && m_k == m_donek) ? eg : 4'd0;
    et = m_act && m_k >= 2 && m_k < m_donek && ((m_k - 1) % P == 0);
    chk("model_gnt",  gnt,  eg);
    chk("model_done", done, ed);
    chk("model_busy", busy, m_act);
    chk("model_tick", tick, et);
  end

  // Per-scenario traces, bit n = value observed in cycle n after the grant sample.
  int          cyc;
  logic [63:0] tick_v, done_v, gnt_v, busy_v;
  logic [19:0] order;

  task automatic clear();
    cyc = 0; tick_v = '0; done_v = '0; gnt_v = '0; busy_v = '0; order = '0;
  endtask

  task automatic step();
    @(posedge i_clk);
    cyc++;
    @(negedge i_clk);
    if (cyc < 64) begin
      tick_v[cyc] = tick; done_v[cyc] = |done; gnt_v[cyc] = |gnt; busy_v[cyc] = busy;
    end
    if (|done) order = {order[15:0], done};
    #1;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge i_clk);
    #1;
    chk("reset_gnt",  gnt,  4'd0);
    chk("reset_done", done, 4'd0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_tick", tick, 1'b0);

    // All four requesting, duration 1: 7-cycle rotation 0,1,2,3,0.
    rst = 1'b0;
    i_dur = {4{16'd1}}; req = 4'hF; clear();
    repeat (34) step();
    req = '0; repeat (2) step();
    chk("rr_order",      order,  20'h12481);
    chk("rr_done_cycles", done_v, 64'h4_0810_2040);

    // Requester 0, duration 3.
    i_dur[15:0] = 16'd3; req = 4'b0001; clear();
    repeat (14) step();
    req = '0; repeat (2) step();
    chk("d3_tick", tick_v, 64'h2220);
    chk("d3_done", done_v, 64'h4000);
    chk("d3_gnt",  gnt_v,  64'h7FFE);
    chk("d3_busy", busy_v, 64'h7FFE);

    // Zero duration on requester 2.
    i_dur[47:32] = 16'd0; req = 4'b0100; clear();
    repeat (2) step();
    req = '0; repeat (2) step();
    chk("d0_done", done_v, 64'h4);
    chk("d0_gnt",  gnt_v,  64'h6);
    chk("d0_tick", tick_v, 64'h0);

    // Abort of requester 1 after cycle 7, then search resumes at index 2.
    i_dur[31:16] = 16'd5; req = 4'b0010; clear();
    repeat (7) step();
    req = '0; repeat (2) step();
    chk("abort_gnt",  gnt_v,  64'hFE);
    chk("abort_busy", busy_v, 64'hFE);
    chk("abort_done", done_v, 64'h0);
    i_dur[15:0] = 16'd1; i_dur[31:16] = 16'd1; req = 4'b0011; clear();
    step();
    chk("rr_after_abort", gnt, 4'b0001);
    repeat (5) step();
    req = '0; repeat (2) step();

    // Reset mid-run.
    i_dur[15:0] = 16'd3; req = 4'b0001; clear();
    repeat (6) step();
    rst = 1'b1;
    #1;
    chk("rst_gnt",  gnt,  4'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tick", tick, 1'b0);
    chk("rst_done", done, 4'd0);
    req = 4'b1000; i_dur[63:48] = 16'd1;
    step();
    chk("rst_no_done", done_v, 64'h0);
    rst = 1'b0; clear();
    step();
    chk("gnt_after_reset", gnt, 4'b1000);
    repeat (5) step();
    req = '0; repeat (2) step();

    // Duration change during RUN is ignored.
    i_dur[15:0] = 16'd3; req = 4'b0001; clear();
    repeat (4) step();
    i_dur[15:0] = 16'd9;
    repeat (10) step();
    req = '0; repeat (2) step();
    chk("dur_change_done", done_v, 64'h4000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
